// File: rtl/binary_counter_pkg.sv
// Shared types and default sizes for the Binary_Counter command driver and its shadow model.
package binary_counter_pkg;

    localparam int unsigned DEF_WIDTH  = 4;
    localparam int unsigned DEF_STEP_W = 8;

    typedef enum logic [1:0] {
        OP_LOAD = 2'd0,
        OP_UP   = 2'd1,
        OP_DOWN = 2'd2,
        OP_HOLD = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } drv_state_e;

endpackage

// File: rtl/binary_counter_shadow.sv
// Shadow copy of the counter, fed from the driver's own strobes; flags any IDLE-time divergence.
// Instantiated only when BINARY_COUNTER_DRIVER_SHADOW_EN is defined.
module binary_counter_shadow
    import binary_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             enable_i,
    input  logic             load_i,
    input  logic             count_i,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic [WIDTH-1:0] a_count_i,
    input  logic             idle_i,
    output logic [WIDTH-1:0] exp_count_o,
    output logic             mismatch_o
);

    logic [WIDTH-1:0] exp_q;
    logic             mismatch_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            exp_q      <= '0;
            mismatch_q <= 1'b0;
        end else begin
            if (load_i) begin
                exp_q <= data_in_i;
            end else if (enable_i) begin
                exp_q <= count_i ? exp_q + WIDTH'(1) : exp_q - WIDTH'(1);
            end
            // Sticky until reset so a transient divergence is never lost.
            if (idle_i && (a_count_i != exp_q)) begin
                mismatch_q <= 1'b1;
            end
        end
    end

    assign exp_count_o = exp_q;
    assign mismatch_o  = mismatch_q;

endmodule

// File: rtl/binary_counter_driver.sv
// Command sequencer driving Binary_Counter's Enable/Load/Count/Data_in and tallying its carries.
// Define BINARY_COUNTER_DRIVER_SHADOW_EN to add the shadow counter model and mismatch flag.
module binary_counter_driver
    import binary_counter_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned STEP_W = DEF_STEP_W
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic [STEP_W-1:0] cmd_steps,
    output logic              Enable,
    output logic              Load,
    output logic              Count,
    output logic [WIDTH-1:0]  Data_in,
    input  logic              C_out,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] carry_cnt
`ifdef BINARY_COUNTER_DRIVER_SHADOW_EN
    ,
    input  logic [WIDTH-1:0]  A_count,
    output logic [WIDTH-1:0]  exp_count,
    output logic              mismatch
`endif
);

    drv_state_e        state_q;
    cmd_op_e           op_q;
    logic [WIDTH-1:0]  data_q;
    logic [STEP_W-1:0] steps_q;
    logic [STEP_W-1:0] carry_q;
    logic [STEP_W-1:0] carry_d;
    logic              enable_q;
    logic              load_q;
    logic              count_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;

    // Carry arrives one cycle after the wrapping edge, so DONE is sampled as well as RUN.
    always_comb begin
        carry_d = carry_q;
        if ((op_q == OP_UP) && C_out && (carry_q != '1)) begin
            carry_d = carry_q + STEP_W'(1);
        end
    end

    // NOTE: state and outputs use non-blocking assignments and a synchronous reset, so every
    // register updates together at the edge and reset only takes effect on a clock edge.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_LOAD;
            data_q   <= '0;
            steps_q  <= '0;
            carry_q  <= '0;
            enable_q <= 1'b0;
            load_q   <= 1'b0;
            count_q  <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && ready_q) begin
                        op_q    <= cmd_op_e'(cmd_op);
                        data_q  <= cmd_data;
                        steps_q <= cmd_steps;
                        carry_q <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (cmd_op_e'(cmd_op) == OP_LOAD) begin
                            state_q  <= ST_LOAD;
                            enable_q <= 1'b1;
                            load_q   <= 1'b1;
                        end else if (cmd_steps == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= ST_RUN;
                            enable_q <= (cmd_op_e'(cmd_op) != OP_HOLD);
                            count_q  <= (cmd_op_e'(cmd_op) == OP_UP);
                        end
                    end
                end
                ST_LOAD: begin
                    state_q  <= ST_DONE;
                    enable_q <= 1'b0;
                    load_q   <= 1'b0;
                    done_q   <= 1'b1;
                end
                ST_RUN: begin
                    carry_q <= carry_d;
                    if (steps_q == STEP_W'(1)) begin
                        state_q  <= ST_DONE;
                        enable_q <= 1'b0;
                        count_q  <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        steps_q <= steps_q - STEP_W'(1);
                    end
                end
                ST_DONE: begin
                    carry_q <= carry_d;
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign Enable    = enable_q;
    assign Load      = load_q;
    assign Count     = count_q;
    assign Data_in   = data_q;
    assign carry_cnt = carry_q;

`ifdef BINARY_COUNTER_DRIVER_SHADOW_EN
    binary_counter_shadow #(
        .WIDTH(WIDTH)
    ) u_shadow (
        .CLK        (CLK),
        .reset      (reset),
        .enable_i   (enable_q),
        .load_i     (load_q),
        .count_i    (count_q),
        .data_in_i  (data_q),
        .a_count_i  (A_count),
        .idle_i     (state_q == ST_IDLE),
        .exp_count_o(exp_count),
        .mismatch_o (mismatch)
    );
`endif

endmodule

// File: tb/tb_binary_counter_driver.sv
// Directed bench for binary_counter_driver with a behavioural Binary_Counter attached.
// Shadow-port checks are compiled only when BINARY_COUNTER_DRIVER_SHADOW_EN is defined.
module tb_binary_counter_driver;

    localparam int W  = 4;
    localparam int SW = 8;

    logic          CLK = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [W-1:0]  cmd_data;
    logic [SW-1:0] cmd_steps;
    logic          Enable, Load, Count;
    logic [W-1:0]  Data_in;
    logic          C_out;
    logic          busy, done;
    logic [SW-1:0] carry_cnt;

    logic          rst_n;
    logic [W-1:0]  cnt;

    int n_cmp = 0;
    int n_err = 0;

`ifdef BINARY_COUNTER_DRIVER_SHADOW_EN
    logic          skew = 1'b0;
    logic [W-1:0]  A_count;
    logic [W-1:0]  exp_count;
    logic          mismatch;
    assign A_count = cnt ^ {{(W-1){1'b0}}, skew};
`endif

    always #5 CLK = ~CLK;

    binary_counter_driver #(.WIDTH(W), .STEP_W(SW)) dut (
        .CLK      (CLK),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .cmd_steps(cmd_steps),
        .Enable   (Enable),
        .Load     (Load),
        .Count    (Count),
        .Data_in  (Data_in),
        .C_out    (C_out),
        .busy     (busy),
        .done     (done),
        .carry_cnt(carry_cnt)
`ifdef BINARY_COUNTER_DRIVER_SHADOW_EN
        ,
        .A_count  (A_count),
        .exp_count(exp_count),
        .mismatch (mismatch)
`endif
    );

    // Behavioural Binary_Counter: carry is registered on the wrapping increment edge.
    assign rst_n = ~reset;
    always @(posedge CLK) begin
        if (!rst_n) begin
            cnt   <= '0;
            C_out <= 1'b0;
        end else begin
            C_out <= Enable && !Load && Count && (cnt == 4'hF);
            if (Enable) begin
                if (Load)       cnt <= Data_in;
                else if (Count) cnt <= cnt + 4'd1;
                else            cnt <= cnt - 4'd1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues one command at a negedge and watches each cycle until done (bounded).
    task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] data, input logic [SW-1:0] steps,
                           output int lat, output int en_n, output int ld_n, output int up_n,
                           output int busy_low, output int first_en);
        int guard;
        lat = 0; en_n = 0; ld_n = 0; up_n = 0; busy_low = 0; first_en = 0;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        check("ready_before_accept", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_steps = steps;
        @(negedge CLK);
        cmd_valid = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            if (Enable) begin
                en_n++;
                if (first_en == 0) first_en = k;
            end
            if (Load)           ld_n++;
            if (Enable && Count) up_n++;
            if (!busy)          busy_low++;
            if (done) begin
                lat = k;
                break;
            end
            @(negedge CLK);
        end
        @(negedge CLK);
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [W-1:0]  data;
        logic [SW-1:0] steps;
        logic [W-1:0]  exp_cnt;
        logic [SW-1:0] exp_carry;
        int            exp_lat;
        int            exp_en;
        int            exp_ld;
        int            exp_up;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int   lat, en_n, ld_n, up_n, busy_low, first_en;
        logic seen_done;

        //          op    data   steps  cnt    carry  lat en ld up
        vecs[0]  = '{2'd0, 4'hA, 8'd0,  4'hA, 8'd0, 2,  1, 1, 0};
        vecs[1]  = '{2'd0, 4'hE, 8'd0,  4'hE, 8'd0, 2,  1, 1, 0};
        vecs[2]  = '{2'd1, 4'h0, 8'd3,  4'h1, 8'd1, 4,  3, 0, 3};
        vecs[3]  = '{2'd0, 4'h2, 8'd0,  4'h2, 8'd0, 2,  1, 1, 0};
        vecs[4]  = '{2'd2, 4'h0, 8'd5,  4'hD, 8'd0, 6,  5, 0, 0};
        vecs[5]  = '{2'd3, 4'h0, 8'd4,  4'hD, 8'd0, 5,  0, 0, 0};
        vecs[6]  = '{2'd1, 4'h0, 8'd0,  4'hD, 8'd0, 1,  0, 0, 0};
        vecs[7]  = '{2'd1, 4'h0, 8'd20, 4'h1, 8'd2, 21, 20, 0, 20};
        vecs[8]  = '{2'd0, 4'hD, 8'd0,  4'hD, 8'd0, 2,  1, 1, 0};
        vecs[9]  = '{2'd1, 4'h0, 8'd3,  4'h0, 8'd1, 4,  3, 0, 3};
        vecs[10] = '{2'd2, 4'h0, 8'd1,  4'hF, 8'd0, 2,  1, 0, 0};
        vecs[11] = '{2'd3, 4'h0, 8'd0,  4'hF, 8'd0, 1,  0, 0, 0};

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = '0; cmd_steps = '0;
        repeat (3) @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);

        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ctrl", {Enable, Load, Count}, 0);
        check("rst_data_in", Data_in, 0);
        check("rst_carry", carry_cnt, 0);

        for (int i = 0; i < 12; i++) begin
            run_cmd(vecs[i].op, vecs[i].data, vecs[i].steps, lat, en_n, ld_n, up_n, busy_low, first_en);
            check($sformatf("v%0d_done_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_enable_cycles", i), en_n, vecs[i].exp_en);
            check($sformatf("v%0d_load_cycles", i), ld_n, vecs[i].exp_ld);
            check($sformatf("v%0d_up_cycles", i), up_n, vecs[i].exp_up);
            check($sformatf("v%0d_busy_held", i), busy_low, 0);
            check($sformatf("v%0d_first_strobe", i), first_en, (vecs[i].exp_en > 0) ? 1 : 0);
            check($sformatf("v%0d_ready_after", i), {cmd_ready, busy}, 2'b10);
            check($sformatf("v%0d_counter", i), cnt, vecs[i].exp_cnt);
            check($sformatf("v%0d_carry_cnt", i), carry_cnt, vecs[i].exp_carry);
        end

        // Reset in the third strobe cycle of UP 10: command dropped, no done pulse.
        check("abort_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 4'h5; cmd_steps = 8'd10;
        @(negedge CLK);
        cmd_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("abort_enable_pre", {Enable, Count, busy}, 3'b111);
        reset = 1'b1;
        @(negedge CLK);
        check("abort_ready_post", cmd_ready, 1);
        check("abort_busy_post", busy, 0);
        check("abort_done_post", done, 0);
        check("abort_ctrl_post", {Enable, Load, Count}, 0);
        check("abort_data_post", Data_in, 0);
        check("abort_carry_post", carry_cnt, 0);
        reset = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge CLK);
            if (done || busy) seen_done = 1'b1;
        end
        check("abort_no_done_later", seen_done, 0);

`ifdef BINARY_COUNTER_DRIVER_SHADOW_EN
        check("shadow_idle_clean", mismatch, 0);
        run_cmd(2'd0, 4'h7, 8'd0, lat, en_n, ld_n, up_n, busy_low, first_en);
        run_cmd(2'd2, 4'h0, 8'd2, lat, en_n, ld_n, up_n, busy_low, first_en);
        check("shadow_exp_count", exp_count, 4'h5);
        check("shadow_no_mismatch", mismatch, 0);
        skew = 1'b1;
        repeat (2) @(negedge CLK);
        check("shadow_mismatch_set", mismatch, 1);
        skew = 1'b0;
        repeat (3) @(negedge CLK);
        check("shadow_mismatch_sticky", mismatch, 1);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        check("shadow_mismatch_cleared", mismatch, 0);
        check("shadow_exp_reset", exp_count, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
